// File: rtl/alu_sequencer_if.sv
// Memory bus between the ALU sequencer and instruction/data memory.
//   mem_addr  : word address, held while a request is pending
//   mem_rd    : read request, held until mem_ready
//   mem_wr    : write request, held until mem_ready
//   mem_wdata : store data
//   mem_rdata : read data, valid in the cycle mem_ready is high
//   mem_ready : the transfer completes on the clock edge where request && ready
// master = sequencer side, slave = memory side.
interface alu_sequencer_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_addr, mem_rd, mem_wr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_addr, mem_rd, mem_wr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/alu_sequencer.sv
// Control sequencer for the register-file ALU. It fetches 16-bit instructions
// over the memory bus, decodes them, and drives the ALU's index, operation,
// params, readBus and din inputs. Only one instruction is in flight at a time.
// Ports:
//   CLK, RST_N     : clock, asynchronous active-low reset
//   bus            : memory bus (master side)
//   alu_readBus    : ALU takes din as its operand2/load source
//   alu_din        : mem_rdata passed straight through
//   alu_dout       : ALU operand1 value (load/store address, store data)
//   alu_op1/op2/res: operand and result register indices
//   alu_operation  : bit6 enable, bits0-5 one-hot ADD/SUB,MUL,LOG,SHL,SHR,CMP
//   alu_params     : ALU params
//   alu_status     : {LT,GT,EQ,N,C,Z}
//   halted         : high in the HALT state
//   illegal        : one-cycle pulse when opcode E/F is executed
module alu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  alu_sequencer_if.master       bus,
  output logic                  alu_readBus,
  output logic [15:0]           alu_din,
  input  logic [15:0]           alu_dout,
  output logic [2:0]            alu_op1,
  output logic [2:0]            alu_op2,
  output logic [2:0]            alu_res,
  output logic [6:0]            alu_operation,
  output logic [3:0]            alu_params,
  input  logic [5:0]            alu_status,
  output logic                  halted,
  output logic                  illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_IMM, S_LD_MEM, S_ST_DATA, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] addr_q, addr_d;
  // Low for the first cycle after reset so every output, mem_rd included,
  // is zero while reset is asserted; fetching starts one cycle after release.
  logic        run_q, run_d;

  logic [3:0] opc;
  logic [2:0] rd, ra, rb;
  logic       cond_true;

  assign opc = ir_q[15:12];
  assign rd  = ir_q[11:9];
  assign ra  = ir_q[8:6];
  assign rb  = ir_q[5:3];

  assign alu_din = bus.mem_rdata;

  // Branch condition, evaluated on the flags present in the IMM cycle.
  always_comb begin
    cond_true = 1'b0;
    case (rd)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = alu_status[0];
      3'd2: cond_true = ~alu_status[0];
      3'd3: cond_true = alu_status[1];
      3'd4: cond_true = alu_status[2];
      3'd5: cond_true = alu_status[3];
      3'd6: cond_true = alu_status[4];
      3'd7: cond_true = alu_status[5];
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    addr_d        = addr_q;
    run_d         = 1'b1;
    bus.mem_addr  = 16'h0000;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = 16'h0000;
    alu_readBus   = 1'b0;
    alu_op1       = 3'd0;
    alu_op2       = 3'd0;
    alu_res       = 3'd0;
    alu_operation = 7'h00;
    alu_params    = 4'h0;
    halted        = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = pc_q;
          if (bus.mem_ready) begin
            ir_d    = bus.mem_rdata;
            pc_d    = pc_q + 16'd1;
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        alu_op1 = ra;
        alu_op2 = rb;
        alu_res = rd;
        state_d = S_FETCH;
        case (opc)
          4'h1: alu_operation = 7'h41;
          4'h2: begin alu_operation = 7'h41; alu_params = 4'h1; end
          4'h3: alu_operation = 7'h42;
          4'h4: begin alu_operation = 7'h44; alu_params = {2'b00, ir_q[1:0]}; end
          // Shifts take their single source through operand2.
          4'h5: begin alu_operation = 7'h48; alu_op2 = ra; alu_params = ir_q[3:0]; end
          4'h6: begin alu_operation = 7'h50; alu_op2 = ra; alu_params = ir_q[3:0]; end
          4'h7: alu_operation = 7'h60;
          4'h8, 4'hB, 4'hC: state_d = S_IMM;
          4'h9: begin addr_d = alu_dout; state_d = S_LD_MEM;  end
          4'hA: begin addr_d = alu_dout; state_d = S_ST_DATA; end
          4'hD: state_d = S_HALT;
          4'hE, 4'hF: illegal = 1'b1;
          default: ;
        endcase
      end

      S_IMM: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = pc_q;
        if (bus.mem_ready) begin
          pc_d    = pc_q + 16'd1;
          state_d = S_FETCH;
          case (opc)
            4'h8: begin
              alu_readBus   = 1'b1;
              alu_operation = 7'h40;
              alu_res       = rd;
            end
            4'hB: pc_d = bus.mem_rdata;
            4'hC: if (cond_true) pc_d = bus.mem_rdata;
            default: ;
          endcase
        end
      end

      S_LD_MEM: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ready) begin
          // The ALU captures din into rd on the same edge the read completes.
          alu_readBus   = 1'b1;
          alu_operation = 7'h40;
          alu_res       = rd;
          state_d       = S_FETCH;
        end
      end

      S_ST_DATA: begin
        alu_op1       = rb;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = alu_dout;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      addr_q  <= 16'h0000;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  alu_sequencer_if bus();

  logic        alu_readBus;
  logic [15:0] alu_din, alu_dout;
  logic [2:0]  alu_op1, alu_op2, alu_res;
  logic [6:0]  alu_operation;
  logic [3:0]  alu_params;
  logic [5:0]  alu_status;
  logic        halted, illegal;

  alu_sequencer #(.RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.master),
    .alu_readBus(alu_readBus), .alu_din(alu_din), .alu_dout(alu_dout),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res),
    .alu_operation(alu_operation), .alu_params(alu_params),
    .alu_status(alu_status), .halted(halted), .illegal(illegal)
  );

  // ---------------- memory model (wait_n wait cycles per transfer) ----------
  logic [15:0] image [0:1023];
  logic [15:0] mem   [0:1023];
  int          wait_n = 0;
  int          wait_cnt;
  logic        req;

  assign req           = bus.mem_rd | bus.mem_wr;
  assign bus.mem_ready = req && (wait_cnt >= wait_n);
  assign bus.mem_rdata = (bus.mem_ready && bus.mem_rd) ? mem[bus.mem_addr[9:0]] : 16'h0000;

  always @(posedge CLK) begin
    if (!RST_N) begin
      wait_cnt <= 0;
      mem      <= image;
    end else if (req) begin
      if (bus.mem_ready) begin
        wait_cnt <= 0;
        if (bus.mem_wr) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // ---------------- register-file ALU model ---------------------------------
  logic [15:0] rf [0:7];
  logic [5:0]  flags, nflags;
  logic [15:0] a_v, b_v, wb;
  logic [16:0] sum;
  logic [31:0] prod;
  logic        we;

  assign alu_dout   = rf[alu_op1];
  assign alu_status = flags;

  always_comb begin
    a_v = rf[alu_op1]; b_v = rf[alu_op2];
    sum = 17'h0; prod = 32'h0; wb = 16'h0; we = 1'b0; nflags = flags;
    if (alu_operation[6]) begin
      if (alu_readBus) begin
        wb = alu_din; we = 1'b1;
      end else if (alu_operation[0]) begin
        sum = alu_params[0] ? ({1'b0, a_v} - {1'b0, b_v}) : ({1'b0, a_v} + {1'b0, b_v});
        wb = sum[15:0]; we = 1'b1;
        nflags[2:0] = {sum[15], sum[16], sum[15:0] == 16'h0};
      end else if (alu_operation[1]) begin
        prod = a_v * b_v; wb = prod[15:0]; we = 1'b1;
      end else if (alu_operation[2]) begin
        case (alu_params[1:0])
          2'd0: wb = a_v & b_v;
          2'd1: wb = a_v | b_v;
          2'd2: wb = a_v ^ b_v;
          default: wb = ~a_v;
        endcase
        we = 1'b1;
      end else if (alu_operation[3]) begin
        wb = a_v << alu_params; we = 1'b1;
      end else if (alu_operation[4]) begin
        wb = a_v >> alu_params; we = 1'b1;
      end else if (alu_operation[5]) begin
        nflags[5:3] = {a_v < b_v, a_v > b_v, a_v == b_v};
      end
    end
  end

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
      flags <= 6'h0;
    end else begin
      if (we) rf[alu_res] <= wb;
      flags <= nflags;
    end
  end

  // ---------------- scoreboard ----------------------------------------------
  int n_chk = 0;
  int n_pass = 0;
  logic [33:0] exp_bus [$];   // {rd, wr, addr, wdata}
  logic [20:0] exp_alu [$];   // {operation, params, op1, op2, res, readBus}
  logic sb_en = 1'b0;
  int   illegal_cnt, req_in_halt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [33:0] br(input logic [15:0] a);
    return {2'b10, a, 16'h0000};
  endfunction
  function automatic logic [33:0] bw(input logic [15:0] a, input logic [15:0] d);
    return {2'b01, a, d};
  endfunction
  function automatic logic [20:0] ae(input logic [6:0] op, input logic [3:0] p,
                                     input logic [2:0] o1, input logic [2:0] o2,
                                     input logic [2:0] r, input logic rbus);
    return {op, p, o1, o2, r, rbus};
  endfunction

  // Monitor: compares every completed bus transfer and every ALU strobe.
  initial begin
    logic        prev_pend;
    logic [17:0] prev_req;
    logic [33:0] e;
    logic [20:0] ea;
    prev_pend = 1'b0;
    prev_req  = 18'h0;
    forever begin
      @(negedge CLK);
      if (!RST_N || !sb_en) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend)
          chk("bus_hold", {bus.mem_rd, bus.mem_wr, bus.mem_addr}, prev_req);
        if (req && bus.mem_ready) begin
          if (exp_bus.size() == 0) begin
            n_chk++;
            $display("FAIL bus_extra: got rd=%b wr=%b addr=%h, no transfer expected",
                     bus.mem_rd, bus.mem_wr, bus.mem_addr);
          end else begin
            e = exp_bus.pop_front();
            chk("bus_xfer", {bus.mem_rd, bus.mem_wr, bus.mem_addr,
                             bus.mem_wr ? bus.mem_wdata : 16'h0000}, e);
          end
        end
        if (alu_operation[6]) begin
          if (exp_alu.size() == 0) begin
            n_chk++;
            $display("FAIL alu_extra: got op=%h res=%0d, no strobe expected", alu_operation, alu_res);
          end else begin
            ea = exp_alu.pop_front();
            chk("alu_strobe", {alu_operation, alu_params, alu_op1, alu_op2, alu_res, alu_readBus}, ea);
          end
        end
        if (illegal) illegal_cnt++;
        if (halted && req) req_in_halt++;
        prev_pend = req && !bus.mem_ready;
        prev_req  = {bus.mem_rd, bus.mem_wr, bus.mem_addr};
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic load_image();
    for (int i = 0; i < 1024; i++) image[i] = 16'h0000;
    image[16'h000] = 16'h8200; image[16'h001] = 16'h0005;  // LDI r1,5
    image[16'h002] = 16'h8400; image[16'h003] = 16'h0003;  // LDI r2,3
    image[16'h004] = 16'h1650;                            // ADD r3=r1+r2
    image[16'h005] = 16'h7050;                            // CMP r1,r2
    image[16'h006] = 16'hCC00; image[16'h007] = 16'h0040;  // BR GT,0x40
    image[16'h040] = 16'h7050;                            // CMP r1,r2
    image[16'h041] = 16'hCE00; image[16'h042] = 16'h0080;  // BR LT (not taken)
    image[16'h043] = 16'h8200; image[16'h044] = 16'h0100;  // LDI r1,0x100
    image[16'h045] = 16'hA050;                            // ST r2->[r1]
    image[16'h046] = 16'h9840;                            // LD r4<-[r1]
    image[16'h047] = 16'h5A44;                            // SHL r5=r1<<4
    image[16'h048] = 16'hF000;                            // illegal
    image[16'h049] = 16'h2C50;                            // SUB r6=r1-r2
    image[16'h04A] = 16'h4E52;                            // LOG xor r7
    image[16'h04B] = 16'h3050;                            // MUL r0=r1*r2
    image[16'h04C] = 16'hB000; image[16'h04D] = 16'h0060;  // JMP 0x60
    image[16'h060] = 16'hD000;                            // HALT
    image[16'h100] = 16'hBEEF;
  endtask

  task automatic push_expect();
    exp_bus.delete(); exp_alu.delete();
    for (int a = 0; a < 8; a++) exp_bus.push_back(br(16'(a)));
    for (int a = 16'h40; a < 16'h46; a++) exp_bus.push_back(br(16'(a)));
    exp_bus.push_back(bw(16'h0100, 16'h0003));
    exp_bus.push_back(br(16'h0046));
    exp_bus.push_back(br(16'h0100));
    for (int a = 16'h47; a < 16'h4E; a++) exp_bus.push_back(br(16'(a)));
    exp_bus.push_back(br(16'h0060));
    exp_alu.push_back(ae(7'h40, 4'h0, 3'd0, 3'd0, 3'd1, 1'b1));
    exp_alu.push_back(ae(7'h40, 4'h0, 3'd0, 3'd0, 3'd2, 1'b1));
    exp_alu.push_back(ae(7'h41, 4'h0, 3'd1, 3'd2, 3'd3, 1'b0));
    exp_alu.push_back(ae(7'h60, 4'h0, 3'd1, 3'd2, 3'd0, 1'b0));
    exp_alu.push_back(ae(7'h60, 4'h0, 3'd1, 3'd2, 3'd0, 1'b0));
    exp_alu.push_back(ae(7'h40, 4'h0, 3'd0, 3'd0, 3'd1, 1'b1));
    exp_alu.push_back(ae(7'h40, 4'h0, 3'd0, 3'd0, 3'd4, 1'b1));
    exp_alu.push_back(ae(7'h48, 4'h4, 3'd1, 3'd1, 3'd5, 1'b0));
    exp_alu.push_back(ae(7'h41, 4'h1, 3'd1, 3'd2, 3'd6, 1'b0));
    exp_alu.push_back(ae(7'h44, 4'h2, 3'd1, 3'd2, 3'd7, 1'b0));
    exp_alu.push_back(ae(7'h42, 4'h0, 3'd1, 3'd2, 3'd0, 1'b0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bus"}, {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 34'h0);
    chk({tag, "_alu"}, {alu_operation, alu_params, alu_op1, alu_op2, alu_res, alu_readBus}, 21'h0);
    chk({tag, "_flags"}, {halted, illegal}, 2'b00);
  endtask

  task automatic run_prog(input int wn);
    int cyc;
    RST_N = 1'b0; sb_en = 1'b0; wait_n = wn;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    push_expect();
    illegal_cnt = 0; req_in_halt = 0;
    sb_en = 1'b1;
    RST_N = 1'b1;
    #1 chk("first_cycle_rd", bus.mem_rd, 1'b0);
    cyc = 0;
    while (!halted && cyc < 3000) begin @(negedge CLK); cyc++; end
    chk("halt_reached", halted, 1'b1);
    repeat (20) @(negedge CLK);
    chk("halt_held", halted, 1'b1);
    chk("halt_no_req", req_in_halt, 0);
    chk("illegal_pulses", illegal_cnt, 1);
    chk("bus_q_empty", exp_bus.size(), 0);
    chk("alu_q_empty", exp_alu.size(), 0);
    chk("r3_add", rf[3], 16'h0008);
    chk("r4_ld", rf[4], 16'h0003);
    chk("r5_shl", rf[5], 16'h1000);
    chk("r6_sub", rf[6], 16'h00FD);
    chk("r0_mul", rf[0], 16'h0300);
    chk("mem_st", mem[16'h100], 16'h0003);
    sb_en = 1'b0;
  endtask

  initial begin
    int cyc;
    #2;
    load_image();
    run_prog(0);
    run_prog(3);

    // Asynchronous reset while a load is waiting on the bus.
    RST_N = 1'b0; wait_n = 4;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("halt_cleared", halted, 1'b0);
    RST_N = 1'b1;
    cyc = 0;
    while (!(bus.mem_rd && bus.mem_addr == 16'h0100) && cyc < 3000) begin
      @(negedge CLK); cyc++;
    end
    chk("ld_mem_seen", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0100});
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("refetch_reset_pc", {bus.mem_rd, bus.mem_wr, bus.mem_addr}, {2'b10, 16'h0000});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
